// File: rtl/rmw_sequencer.sv
// rmw_sequencer: runs the read / dummy-write / write bus sequence of 6502 read-modify-write ops,
// drives the shared ALU and returns NZC flags.
package rmw_sequencer_pkg;
   typedef enum logic [2:0] {ALU_NOP, ALU_SHIFTL, ALU_SHIFTR, ALU_ADC, ALU_SBC} alu_op_e;
endpackage

module rmw_sequencer
   import rmw_sequencer_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter bit DUMMY_WRITE = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [2:0]        rmw_op_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              carry_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic              flag_n_o,
   output logic              flag_z_o,
   output logic              flag_c_o,
   output logic              flag_c_we_o,
   output logic [7:0]        alu_a_o,
   output logic [7:0]        alu_b_o,
   output alu_op_e           alu_op_o,
   output logic              alu_carry_o,
   input  logic [7:0]        alu_res_i,
   input  logic              alu_carry_i,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic              bus_rd_o,
   output logic              bus_wr_o,
   output logic [7:0]        bus_wdata_o,
   input  logic [7:0]        bus_rdata_i,
   input  logic              bus_ready_i
);
   typedef enum logic [1:0] {IDLE, READ, MID, WRITE} state_e;
   state_e     state;
   logic [7:0] res;
   logic       res_c;
   logic       shift_op;
   logic       legal;

   assign legal   = rmw_op_i < 3'd6;
   assign alu_b_o = 8'h00;

   // alu_a_o doubles as the data register holding the byte read in READ
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         state       <= IDLE;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
         err_o       <= 1'b0;
         flag_n_o    <= 1'b0;
         flag_z_o    <= 1'b0;
         flag_c_o    <= 1'b0;
         flag_c_we_o <= 1'b0;
         alu_a_o     <= 8'h00;
         alu_op_o    <= ALU_NOP;
         alu_carry_o <= 1'b0;
         bus_addr_o  <= '0;
         bus_rd_o    <= 1'b0;
         bus_wr_o    <= 1'b0;
         bus_wdata_o <= 8'h00;
         res         <= 8'h00;
         res_c       <= 1'b0;
         shift_op    <= 1'b0;
      end else begin
         done_o <= 1'b0;
         err_o  <= 1'b0;
         case (state)
            IDLE: if (start_i) begin
               if (legal) begin
                  state       <= READ;
                  busy_o      <= 1'b1;
                  bus_addr_o  <= addr_i;
                  bus_rd_o    <= 1'b1;
                  shift_op    <= ~rmw_op_i[2];
                  alu_op_o    <= rmw_op_i[2] ? (rmw_op_i[0] ? ALU_SBC : ALU_ADC)
                                             : (rmw_op_i[0] ? ALU_SHIFTR : ALU_SHIFTL);
                  // ROL/ROR feed C, INC adds 1, DEC uses borrow-in (c=0) to subtract 1
                  alu_carry_o <= rmw_op_i[2] ? ~rmw_op_i[0] : (rmw_op_i[1] & carry_i);
               end else
                  err_o <= 1'b1;
            end
            READ: if (bus_ready_i) begin
               state       <= MID;
               alu_a_o     <= bus_rdata_i;
               bus_rd_o    <= 1'b0;
               bus_wr_o    <= DUMMY_WRITE;
               bus_wdata_o <= DUMMY_WRITE ? bus_rdata_i : 8'h00;
            end
            MID: if (bus_ready_i || !DUMMY_WRITE) begin
               state       <= WRITE;
               res         <= alu_res_i;
               res_c       <= alu_carry_i;
               bus_wr_o    <= 1'b1;
               bus_wdata_o <= alu_res_i;
            end
            WRITE: if (bus_ready_i) begin
               state       <= IDLE;
               busy_o      <= 1'b0;
               done_o      <= 1'b1;
               bus_wr_o    <= 1'b0;
               bus_wdata_o <= 8'h00;
               bus_addr_o  <= '0;
               flag_n_o    <= res[7];
               flag_z_o    <= res == 8'h00;
               flag_c_o    <= res_c;
               flag_c_we_o <= shift_op;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_rmw_sequencer.sv
// tb_rmw_sequencer: table-driven checks of rmw_sequencer against a behavioural ALU and bus
module tb_rmw_sequencer;
   import rmw_sequencer_pkg::*;

   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, carry = 1'b0, ready = 1'b1;
   logic [2:0]  op = 3'd0;
   logic [15:0] addr = 16'h0000;
   logic [7:0]  rdata = 8'h00;
   logic        busy, done, err, fn, fz, fc, fcwe, alu_ci, bus_rd, bus_wr;
   logic [7:0]  alu_a, alu_b, alu_res, bus_wdata;
   logic        alu_co;
   alu_op_e     alu_op;
   logic [15:0] bus_addr;

   int checks = 0;
   int fails  = 0;

   typedef struct {
      logic [2:0]  op;
      logic [15:0] addr;
      logic        c;
      logic [7:0]  rd;
      logic [7:0]  wd;
      logic        n, z, cf, cwe;
   } vec_t;
   vec_t tab[7];

   rmw_sequencer dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .rmw_op_i(op), .addr_i(addr), .carry_i(carry),
      .busy_o(busy), .done_o(done), .err_o(err), .flag_n_o(fn), .flag_z_o(fz), .flag_c_o(fc),
      .flag_c_we_o(fcwe), .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_op_o(alu_op), .alu_carry_o(alu_ci),
      .alu_res_i(alu_res), .alu_carry_i(alu_co), .bus_addr_o(bus_addr), .bus_rd_o(bus_rd),
      .bus_wr_o(bus_wr), .bus_wdata_o(bus_wdata), .bus_rdata_i(rdata), .bus_ready_i(ready)
   );

   always #5 clk = ~clk;

   // 6502-style ALU: SBC carry is "no borrow"
   always_comb begin
      alu_res = 8'h00;
      alu_co  = 1'b0;
      case (alu_op)
         ALU_SHIFTL: {alu_co, alu_res} = {alu_a, alu_ci};
         ALU_SHIFTR: {alu_res, alu_co} = {alu_ci, alu_a};
         ALU_ADC:    {alu_co, alu_res} = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_ci};
         ALU_SBC:    {alu_co, alu_res} = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'h00, alu_ci};
         default: ;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic run(input vec_t v, input int stall, input bit poke);
      int          cyc, sl, rn, wn;
      logic [15:0] ra;
      logic [15:0] wa[2];
      logic [7:0]  wd[2];
      ra = 16'h0; wa = '{16'h0, 16'h0}; wd = '{8'h0, 8'h0};
      @(negedge clk);
      start = 1'b1; op = v.op; addr = v.addr; carry = v.c; rdata = v.rd;
      @(posedge clk); #1;
      start = 1'b0;
      cyc = 1; sl = stall; rn = 0; wn = 0;
      while (!done && cyc < 30) begin
         if (bus_rd && sl > 0) begin
            ready = 1'b0;
            sl--;
            chk("stall_addr", bus_addr, v.addr);
         end else
            ready = 1'b1;
         if (poke && cyc == 2) begin
            start = 1'b1; op = 3'd1; addr = 16'hBEEF; carry = ~v.c;
         end else
            start = 1'b0;
         if (bus_rd && ready) begin rn++; ra = bus_addr; end
         if (bus_wr && ready) begin
            if (wn < 2) begin wa[wn] = bus_addr; wd[wn] = bus_wdata; end
            wn++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      ready = 1'b1; start = 1'b0;
      chk("done_cycle", cyc, 4 + stall);
      chk("read_count", rn, 1);
      chk("read_addr", ra, v.addr);
      chk("write_count", wn, 2);
      chk("dummy_addr", wa[0], v.addr);
      chk("dummy_data", wd[0], v.rd);
      chk("final_addr", wa[1], v.addr);
      chk("final_data", wd[1], v.wd);
      chk("flag_n", fn, v.n);
      chk("flag_z", fz, v.z);
      chk("flag_c", fc, v.cf);
      chk("flag_c_we", fcwe, v.cwe);
      chk("busy_at_done", busy, 0);
   endtask

   initial begin
      int bad;
      tab[0] = '{3'd0, 16'h0010, 1'b0, 8'h81, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1};
      tab[1] = '{3'd3, 16'h0200, 1'b1, 8'h01, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1};
      tab[2] = '{3'd5, 16'h0300, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0};
      tab[3] = '{3'd4, 16'h0301, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
      tab[4] = '{3'd1, 16'h1234, 1'b1, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1};
      tab[5] = '{3'd2, 16'hFFFF, 1'b1, 8'h40, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1};
      tab[6] = '{3'd0, 16'h0000, 1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};

      #2;
      chk("rst_busy", busy, 0);
      chk("rst_strobes", {bus_rd, bus_wr}, 0);
      chk("rst_addr", bus_addr, 0);
      chk("rst_flags", {fn, fz, fc, fcwe, done, err}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 7; i++) run(tab[i], 0, 1'b0);
      run(tab[0], 3, 1'b0);
      run(tab[1], 0, 1'b1);
      run(tab[6], 0, 1'b0);

      @(negedge clk);
      start = 1'b1; op = 3'd0; addr = 16'h0400; carry = 1'b0; rdata = 8'h81;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk("pre_rst_write", bus_wr, 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_wr", bus_wr, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_addr", bus_addr, 0);
      chk("rst_mid_flags", {fn, fz, fc, fcwe}, 0);
      @(negedge clk);
      rst = 1'b0;
      bad = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (done || bus_rd || bus_wr || busy) bad++;
      end
      chk("rst_abandon", bad, 0);
      run(tab[0], 0, 1'b0);

      for (int k = 6; k < 8; k++) begin
         @(negedge clk);
         start = 1'b1; op = 3'(k);
         @(posedge clk); #1;
         start = 1'b0;
         chk("err_pulse", err, 1);
         chk("err_busy", busy, 0);
         @(posedge clk); #1;
         chk("err_clear", err, 0);
         chk("err_idle", {busy, bus_rd}, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, fails);
      $fatal(1);
   end
endmodule
